// File: rtl/cpu_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_axi_pkg
// Purpose  : Shared definitions for the CPU-to-AXI bridge: read/write FSM
//            state encodings, AXI ID assignments and the constant AXI
//            attribute fields driven on every transfer.
// Revision : 1.0  initial release
// ============================================================================
package cpu_axi_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_R    = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_B    = 2'd2
  } wr_state_e;

  // Read IDs double as the response routing key: 0 goes to fetch, 1 to data.
  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  // Single-beat, non-cacheable, unprivileged INCR transfers only.
  localparam logic [7:0] AXI_LEN   = 8'd0;
  localparam logic [1:0] AXI_BURST = 2'b01;
  localparam logic [1:0] AXI_LOCK  = 2'b00;
  localparam logic [3:0] AXI_CACHE = 4'd0;
  localparam logic [2:0] AXI_PROT  = 3'd0;

  // SRAM size code (0/1/2) maps directly onto AXI AxSIZE (1/2/4 bytes).
  function automatic logic [2:0] sram_to_axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axi_wr_ctrl
// Purpose  : Single-outstanding AXI write engine. Latches one store, then
//            presents AW and W concurrently, tracking each handshake on its
//            own so either may complete first, then waits for B.
// Ports    : clk, resetn          - clock, synchronous active-low reset
//            store_go             - store accepted this cycle (only in idle)
//            addr/size/strb/data  - store request fields to latch
//            aw*/w*/b*            - AXI write channels
//            idle                 - engine can accept a new store
// Revision : 1.0  initial release
// ============================================================================
module axi_wr_ctrl
  import cpu_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                store_go,
  input  logic [ADDR_W-1:0]   st_addr,
  input  logic [1:0]          st_size,
  input  logic [DATA_W/8-1:0] st_strb,
  input  logic [DATA_W-1:0]   st_data,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awsize,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic                bvalid,
  output logic                bready,
  output logic                idle
);

  wr_state_e             r_state, w_next;
  logic                  r_aw_done, r_w_done;
  logic [ADDR_W-1:0]     r_addr;
  logic [1:0]            r_size;
  logic [DATA_W/8-1:0]   r_strb;
  logic [DATA_W-1:0]     r_data;
  logic                  w_aw_fin, w_w_fin;

  // A channel counts as finished if it completed earlier or completes now.
  assign w_aw_fin = r_aw_done | (awvalid & awready);
  assign w_w_fin  = r_w_done  | (wvalid  & wready);

  always_comb begin
    w_next = r_state;
    case (r_state)
      W_IDLE:  if (store_go)             w_next = W_REQ;
      W_REQ:   if (w_aw_fin && w_w_fin)  w_next = W_B;
      W_B:     if (bvalid)               w_next = W_IDLE;
      default:                           w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= W_IDLE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_addr    <= '0;
      r_size    <= '0;
      r_strb    <= '0;
      r_data    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == W_IDLE) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        if (store_go) begin
          r_addr <= st_addr;
          r_size <= st_size;
          r_strb <= st_strb;
          r_data <= st_data;
        end
      end else if (r_state == W_REQ) begin
        r_aw_done <= w_aw_fin;
        r_w_done  <= w_w_fin;
      end
    end
  end

  // Valids come from registered state only, so they cannot glitch or drop
  // before their own handshake.
  assign awvalid = (r_state == W_REQ) & ~r_aw_done;
  assign wvalid  = (r_state == W_REQ) & ~r_w_done;
  assign bready  = (r_state == W_B);
  assign idle    = (r_state == W_IDLE);
  assign awaddr  = r_addr;
  assign awsize  = sram_to_axi_size(r_size);
  assign wdata   = r_data;
  assign wstrb   = r_strb;

endmodule
`default_nettype wire

// File: rtl/cpu_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : cpu_axi_bridge
// Purpose  : Arbitrates the fetch and data SRAM-like ports onto one AXI3
//            master. Owns the shared read channel (data load beats fetch),
//            delegates stores to axi_wr_ctrl, and routes responses by ID.
// Ports    : clk, resetn      - clock, synchronous active-low reset
//            inst_sram_*      - fetch port (read only)
//            data_sram_*      - load/store port
//            ar*/r*/aw*/w*/b* - AXI3 master channels
// Revision : 1.0  initial release
// ============================================================================
module cpu_axi_bridge
  import cpu_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_sram_req,
  input  logic                inst_sram_wr,
  input  logic [1:0]          inst_sram_size,
  input  logic [ADDR_W-1:0]   inst_sram_addr,
  output logic                inst_sram_addr_ok,
  output logic                inst_sram_data_ok,
  output logic [DATA_W-1:0]   inst_sram_rdata,
  input  logic                data_sram_req,
  input  logic                data_sram_wr,
  input  logic [1:0]          data_sram_size,
  input  logic [DATA_W/8-1:0] data_sram_wstrb,
  input  logic [ADDR_W-1:0]   data_sram_addr,
  input  logic [DATA_W-1:0]   data_sram_wdata,
  output logic                data_sram_addr_ok,
  output logic                data_sram_data_ok,
  output logic [DATA_W-1:0]   data_sram_rdata,
  output logic [3:0]          arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [3:0]          rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [3:0]          awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [3:0]          wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [3:0]          bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  rd_state_e           r_rd_state, w_rd_next;
  logic [ADDR_W-1:0]   r_araddr;
  logic [1:0]          r_arsize;
  logic [3:0]          r_arid;
  logic                w_rd_idle, w_wr_idle, w_rd_serving_data;
  logic                w_load_grant, w_inst_grant, w_store_grant;
  logic                w_unused;

  // Write direction is fixed per port and error responses are not reported.
  assign w_unused = ^{inst_sram_wr, rresp, bresp, bid};

  assign w_rd_idle         = (r_rd_state == R_IDLE);
  // r_arid is stale in idle, so only trust it while a read is active.
  assign w_rd_serving_data = ~w_rd_idle & (r_arid == ID_DATA);

  // Loads wait for the write engine to drain (read-after-write ordering);
  // stores wait for an outstanding load so data-port responses stay in order.
  assign w_load_grant  = data_sram_req & ~data_sram_wr & w_rd_idle & w_wr_idle;
  assign w_inst_grant  = inst_sram_req & w_rd_idle & ~w_load_grant;
  assign w_store_grant = data_sram_req & data_sram_wr & w_wr_idle & ~w_rd_serving_data;

  assign inst_sram_addr_ok = w_inst_grant;
  assign data_sram_addr_ok = w_load_grant | w_store_grant;

  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      R_IDLE:  if (w_load_grant || w_inst_grant) w_rd_next = R_AR;
      R_AR:    if (arready)                      w_rd_next = R_R;
      R_R:     if (rvalid && rlast)              w_rd_next = R_IDLE;
      default:                                   w_rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rd_state <= R_IDLE;
      r_araddr   <= '0;
      r_arsize   <= '0;
      r_arid     <= '0;
    end else begin
      r_rd_state <= w_rd_next;
      if (w_load_grant) begin
        r_araddr <= data_sram_addr;
        r_arsize <= data_sram_size;
        r_arid   <= ID_DATA;
      end else if (w_inst_grant) begin
        r_araddr <= inst_sram_addr;
        r_arsize <= inst_sram_size;
        r_arid   <= ID_INST;
      end
    end
  end

  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arsize  = sram_to_axi_size(r_arsize);
  assign arvalid = (r_rd_state == R_AR);
  assign rready  = (r_rd_state == R_R);
  assign arlen   = AXI_LEN;
  assign arburst = AXI_BURST;
  assign arlock  = AXI_LOCK;
  assign arcache = AXI_CACHE;
  assign arprot  = AXI_PROT;

  axi_wr_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_ctrl (
    .clk      (clk),
    .resetn   (resetn),
    .store_go (w_store_grant),
    .st_addr  (data_sram_addr),
    .st_size  (data_sram_size),
    .st_strb  (data_sram_wstrb),
    .st_data  (data_sram_wdata),
    .awaddr   (awaddr),
    .awsize   (awsize),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wvalid   (wvalid),
    .wready   (wready),
    .bvalid   (bvalid),
    .bready   (bready),
    .idle     (w_wr_idle)
  );

  assign awid    = ID_DATA;
  assign wid     = ID_DATA;
  assign wlast   = 1'b1;
  assign awlen   = AXI_LEN;
  assign awburst = AXI_BURST;
  assign awlock  = AXI_LOCK;
  assign awcache = AXI_CACHE;
  assign awprot  = AXI_PROT;

  assign inst_sram_data_ok = rvalid & rready & (rid == ID_INST);
  assign data_sram_data_ok = (rvalid & rready & (rid == ID_DATA)) | (bvalid & bready);
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

endmodule
`default_nettype wire
